// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute/predictor-update signal bundle for branch_resolve_unit.
// slave = the resolve unit itself; master = whatever drives fetch/exec and consumes the update bus.
interface branch_resolve_unit_if;
    logic        fetch_push;
    logic [31:0] fetch_PC4;
    logic        fetch_p_dir;
    logic [31:0] fetch_p_target;
    logic [3:0]  fetch_ras_index;
    logic        exec_valid;
    logic        exec_taken;
    logic [31:0] exec_target;
    logic        soin_bpredictor_stall;
    logic        fetch_redirect;
    logic [31:0] fetch_redirect_PC;
    logic        execute_bpredictor_update;
    logic [31:0] execute_bpredictor_PC4;
    logic [31:0] execute_bpredictor_target;
    logic        execute_bpredictor_dir;
    logic        execute_bpredictor_miss;
    logic        execute_bpredictor_recover_ras;
    logic [3:0]  execute_bpredictor_meta;
    logic        resolve_underflow;

    modport slave (
        input  fetch_push, fetch_PC4, fetch_p_dir, fetch_p_target, fetch_ras_index,
        input  exec_valid, exec_taken, exec_target,
        output soin_bpredictor_stall, fetch_redirect, fetch_redirect_PC,
        output execute_bpredictor_update, execute_bpredictor_PC4, execute_bpredictor_target,
        output execute_bpredictor_dir, execute_bpredictor_miss, execute_bpredictor_recover_ras,
        output execute_bpredictor_meta, resolve_underflow
    );

    modport master (
        output fetch_push, fetch_PC4, fetch_p_dir, fetch_p_target, fetch_ras_index,
        output exec_valid, exec_taken, exec_target,
        input  soin_bpredictor_stall, fetch_redirect, fetch_redirect_PC,
        input  execute_bpredictor_update, execute_bpredictor_PC4, execute_bpredictor_target,
        input  execute_bpredictor_dir, execute_bpredictor_miss, execute_bpredictor_recover_ras,
        input  execute_bpredictor_meta, resolve_underflow
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order queue of predicted branches, resolved against execute outcomes to drive predictor update/redirect.
// Latency: resolve -> update/redirect pulse 1 cycle. Backpressure: stall while queue full; redirect squashes pushes.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input logic             clk,
    input logic             reset,
    branch_resolve_unit_if.slave bus
);
    typedef struct packed {
        logic [31:0] pc4;
        logic        p_dir;
        logic [31:0] p_target;
        logic [3:0]  ras_index;
    } entry_t;

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic        update_q, update_d, miss_q, miss_d, redirect_q, redirect_d;
    logic        dir_q, dir_d, underflow_q, underflow_d;
    logic [31:0] pc4_q, pc4_d, target_q, target_d, rpc_q, rpc_d;
    logic [3:0]  meta_q, meta_d;

    entry_t head;
    logic   pop, push_ok, miss, flush;

    always_comb begin
        head    = mem_q[rd_ptr_q];
        pop     = bus.exec_valid && (count_q != '0);
        miss    = (head.p_dir != bus.exec_taken) ||
                  (bus.exec_taken && (head.p_target != bus.exec_target));
        flush   = pop && miss;
        // A pop in the same cycle frees the slot, so a push at full is still accepted.
        push_ok = bus.fetch_push && !redirect_q && ((count_q != FULL) || pop);

        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = '{pc4: bus.fetch_PC4, p_dir: bus.fetch_p_dir,
                                    p_target: bus.fetch_p_target, ras_index: bus.fetch_ras_index};
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push_ok) count_d = count_q - 1'b1;
        end

        update_d    = pop;
        miss_d      = flush;
        redirect_d  = flush;
        pc4_d       = pc4_q;
        target_d    = target_q;
        dir_d       = dir_q;
        meta_d      = meta_q;
        rpc_d       = rpc_q;
        if (pop) begin
            pc4_d    = head.pc4;
            target_d = bus.exec_target;
            dir_d    = bus.exec_taken;
            meta_d   = head.ras_index;
        end
        if (flush) rpc_d = bus.exec_taken ? bus.exec_target : head.pc4;
        underflow_d = underflow_q || (bus.exec_valid && (count_q == '0));
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            update_q    <= 1'b0;
            miss_q      <= 1'b0;
            redirect_q  <= 1'b0;
            dir_q       <= 1'b0;
            underflow_q <= 1'b0;
            pc4_q       <= '0;
            target_q    <= '0;
            rpc_q       <= '0;
            meta_q      <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            update_q    <= update_d;
            miss_q      <= miss_d;
            redirect_q  <= redirect_d;
            dir_q       <= dir_d;
            underflow_q <= underflow_d;
            pc4_q       <= pc4_d;
            target_q    <= target_d;
            rpc_q       <= rpc_d;
            meta_q      <= meta_d;
        end
    end

    assign bus.soin_bpredictor_stall          = (count_q == FULL);
    assign bus.fetch_redirect                 = redirect_q;
    assign bus.fetch_redirect_PC              = rpc_q;
    assign bus.execute_bpredictor_update      = update_q;
    assign bus.execute_bpredictor_PC4         = pc4_q;
    assign bus.execute_bpredictor_target      = target_q;
    assign bus.execute_bpredictor_dir         = dir_q;
    assign bus.execute_bpredictor_miss        = miss_q;
    assign bus.execute_bpredictor_recover_ras = miss_q;
    assign bus.execute_bpredictor_meta        = meta_q;
    assign bus.resolve_underflow              = underflow_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus random bench for branch_resolve_unit against a queue-based model of the branch record list.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_resolve_unit_if bi ();

    branch_resolve_unit #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bi.slave)
    );

    typedef struct {
        logic [31:0] pc4;
        logic        pdir;
        logic [31:0] tgt;
        logic [3:0]  ras;
    } rec_t;

    rec_t q[$];
    int   errors = 0;
    int   checks = 0;

    logic        e_upd, e_miss, e_redir, e_dir, e_uf;
    logic [31:0] e_pc4, e_tgt, e_rpc;
    logic [3:0]  e_meta;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic rst, input logic push, input logic [31:0] pc4,
                        input logic pdir, input logic [31:0] ptgt, input logic [3:0] ras,
                        input logic ev, input logic et, input logic [31:0] etgt);
        rec_t h;
        bit   pop, pok, m;
        reset              = rst;
        bi.fetch_push      = push;
        bi.fetch_PC4       = pc4;
        bi.fetch_p_dir     = pdir;
        bi.fetch_p_target  = ptgt;
        bi.fetch_ras_index = ras;
        bi.exec_valid      = ev;
        bi.exec_taken      = et;
        bi.exec_target     = etgt;
        m = 1'b0;
        if (rst) begin
            q.delete();
            e_upd = 0; e_miss = 0; e_redir = 0; e_dir = 0; e_uf = 0;
            e_pc4 = 0; e_tgt = 0; e_rpc = 0; e_meta = 0;
        end else begin
            pop = ev && (q.size() != 0);
            pok = push && !e_redir && ((q.size() < DEPTH) || pop);
            if (ev && q.size() == 0) e_uf = 1'b1;
            e_upd = pop; e_miss = 0; e_redir = 0;
            if (pop) begin
                h = q.pop_front();
                m = (h.pdir != et) || (et && (h.tgt != etgt));
                e_pc4 = h.pc4; e_tgt = etgt; e_dir = et; e_meta = h.ras;
                e_miss = m; e_redir = m;
                if (m) e_rpc = et ? etgt : h.pc4;
            end
            if (pop && m) q.delete();
            else if (pok) q.push_back('{pc4, pdir, ptgt, ras});
        end
        @(posedge clk);
        #1;
        chk("update",    bi.execute_bpredictor_update, e_upd);
        chk("miss",      bi.execute_bpredictor_miss, e_miss);
        chk("recover",   bi.execute_bpredictor_recover_ras, e_miss);
        chk("redirect",  bi.fetch_redirect, e_redir);
        chk("redir_pc",  bi.fetch_redirect_PC, e_rpc);
        chk("pc4",       bi.execute_bpredictor_PC4, e_pc4);
        chk("target",    bi.execute_bpredictor_target, e_tgt);
        chk("dir",       bi.execute_bpredictor_dir, e_dir);
        chk("meta",      bi.execute_bpredictor_meta, e_meta);
        chk("underflow", bi.resolve_underflow, e_uf);
        chk("stall",     bi.soin_bpredictor_stall, (q.size() == DEPTH));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic psh(input logic [31:0] pc4, input logic pdir, input logic [31:0] tgt, input logic [3:0] ras);
        step(0, 1, pc4, pdir, tgt, ras, 0, 0, 0);
    endtask
    task automatic res(input logic et, input logic [31:0] tgt);
        step(0, 0, 0, 0, 0, 0, 1, et, tgt);
    endtask

    initial begin
        logic        r_push, r_pdir, r_ev, r_et, r_rst;
        logic [31:0] r_pc4, r_ptgt, r_etgt;
        logic [3:0]  r_ras;

        // reset state
        do_reset();
        chk("rst_update", bi.execute_bpredictor_update, 0);
        chk("rst_rpc", bi.fetch_redirect_PC, 0);

        // correct taken prediction
        psh(32'h104, 1, 32'h200, 4'd3);
        res(1, 32'h200);
        chk("ct_update", bi.execute_bpredictor_update, 1);
        chk("ct_miss", bi.execute_bpredictor_miss, 0);
        chk("ct_redirect", bi.fetch_redirect, 0);
        chk("ct_pc4", bi.execute_bpredictor_PC4, 32'h104);
        chk("ct_dir", bi.execute_bpredictor_dir, 1);
        chk("ct_meta", bi.execute_bpredictor_meta, 3);
        idle();
        chk("ct_pulse_end", bi.execute_bpredictor_update, 0);
        chk("ct_hold_pc4", bi.execute_bpredictor_PC4, 32'h104);

        // direction miss with three younger records flushed
        psh(32'h108, 0, 32'h0, 4'd5);
        psh(32'h20, 1, 32'h1000, 4'd1);
        psh(32'h24, 0, 32'h1010, 4'd2);
        psh(32'h28, 1, 32'h1020, 4'd3);
        chk("full_stall", bi.soin_bpredictor_stall, 1);
        res(1, 32'h300);
        chk("dm_miss", bi.execute_bpredictor_miss, 1);
        chk("dm_recover", bi.execute_bpredictor_recover_ras, 1);
        chk("dm_redirect", bi.fetch_redirect, 1);
        chk("dm_rpc", bi.fetch_redirect_PC, 32'h300);
        chk("dm_stall", bi.soin_bpredictor_stall, 0);
        // push in the redirect cycle is squashed, so the next resolve underflows
        psh(32'h500, 0, 32'h0, 4'd7);
        res(0, 32'h0);
        chk("uf_update", bi.execute_bpredictor_update, 0);
        chk("uf_flag", bi.resolve_underflow, 1);
        idle();
        chk("uf_sticky", bi.resolve_underflow, 1);

        // target miss, then not-taken miss
        do_reset();
        psh(32'h110, 1, 32'h400, 4'd1);
        res(1, 32'h480);
        chk("tm_rpc", bi.fetch_redirect_PC, 32'h480);
        idle();
        psh(32'h10C, 1, 32'h600, 4'd2);
        res(0, 32'h0);
        chk("nt_rpc", bi.fetch_redirect_PC, 32'h10C);
        chk("nt_dir", bi.execute_bpredictor_dir, 0);

        // full boundary, dropped push, push+pop at full across wrap
        do_reset();
        for (int i = 0; i < 4; i++) psh(32'h40 + 4 * i, 0, 32'h0, 4'(i));
        chk("fb_stall", bi.soin_bpredictor_stall, 1);
        psh(32'h999, 0, 32'h0, 4'd9);
        for (int i = 0; i < 8; i++) step(0, 1, 32'h80 + 4 * i, 1, 32'h2000 + 16 * i, 4'(i), 1, q[0].pdir, q[0].tgt);
        chk("fb_stall_kept", bi.soin_bpredictor_stall, 1);
        for (int i = 0; i < 4; i++) res(q[0].pdir, q[0].tgt);
        chk("fb_last_pc4", bi.execute_bpredictor_PC4, 32'h9C);

        // reset mid-flight with a miss pending
        do_reset();
        for (int i = 0; i < 3; i++) psh(32'h60 + 4 * i, 0, 32'h0, 4'd4);
        step(1, 0, 0, 0, 0, 0, 1, 1, 32'h777);
        chk("mr_redirect", bi.fetch_redirect, 0);
        chk("mr_stall", bi.soin_bpredictor_stall, 0);
        res(0, 32'h0);
        chk("mr_empty_uf", bi.resolve_underflow, 1);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r_rst  = ($urandom % 97) == 0;
            r_push = ($urandom % 3) != 0;
            r_pc4  = $urandom & 32'hFFFF_FFFC;
            r_pdir = 1'($urandom);
            r_ptgt = 32'h3000 + 32'(($urandom % 4) * 16);
            r_ras  = 4'($urandom);
            r_ev   = 1'($urandom);
            r_etgt = 32'h3000 + 32'(($urandom % 4) * 16);
            r_et   = 1'($urandom);
            if (q.size() != 0 && ($urandom % 4) != 0) begin
                r_et = q[0].pdir;
                if (q[0].pdir) r_etgt = q[0].tgt;
            end
            step(r_rst, r_push, r_pc4, r_pdir, r_ptgt, r_ras, r_ev, r_et, r_etgt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
